// File: rtl/vga_line_fetch_arbiter.sv
// Framebuffer arbiter: prefetches the next scan line during hblank, grants host writes otherwise.
// Latency: pixel 1 cycle after hpos; host write reaches RAM port 1 cycle after acceptance; fetch 21 cycles.
// Backpressure: host_ready is low whenever a fetch starts or runs; an unaccepted host_valid is simply held.
module vga_line_fetch_arbiter #(
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 20,
  parameter int ADDR_W         = 14,
  parameter int H_DISPLAY      = 640,
  parameter int H_MAX          = 799,
  parameter int V_DISPLAY      = 480,
  parameter int V_MAX          = 524
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              display_on,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pixel,
  output logic              underrun
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_d;
  logic               cap_vld;
  logic [ADDR_W-1:0]  line_base;
  logic [DATA_W-1:0]  front_buf [WORDS_PER_LINE];
  logic [DATA_W-1:0]  back_buf  [WORDS_PER_LINE];
  logic               back_full;
  logic               fetch_started;
  logic               fetch_start;
  logic               swap_point;
  logic [9:0]         target_line;
  logic [ADDR_W-1:0]  next_base;
  logic [4:0]         word_sel;
  logic [DATA_W-1:0]  cur_word;

  // Fetch trigger: start of hblank on every line whose successor is visible, plus the last frame line.
  always_comb begin
    fetch_start = (hpos == 10'(H_DISPLAY)) &&
                  ((vpos < 10'(V_DISPLAY - 1)) || (vpos == 10'(V_MAX)));
    swap_point  = (hpos == 10'(H_MAX));
    target_line = (vpos == 10'(V_MAX)) ? 10'd0 : vpos + 10'd1;
    next_base   = ADDR_W'(target_line) * ADDR_W'(WORDS_PER_LINE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and host grant; the fetch always wins over the host.
  always_comb begin
    state_nxt  = state;
    host_ready = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_start) state_nxt  = FETCH;
        else             host_ready = 1'b1;
      end
      FETCH: begin
        if (idx == IDX_W'(WORDS_PER_LINE - 1)) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port driver: read addresses while fetching, host writes while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      idx       <= '0;
      line_base <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_start) begin
            idx       <= '0;
            line_base <= next_base;
          end else if (host_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= host_addr;
            mem_wdata <= host_data;
          end
        end
        FETCH: begin
          mem_addr <= line_base + ADDR_W'(idx);
          idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read data returns one cycle after the address goes out; track which slot it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld <= 1'b0;
      idx_d   <= '0;
    end else begin
      cap_vld <= (state == FETCH);
      idx_d   <= idx;
    end
  end

  // Line store: fill the back buffer, swap into the front at end of line, flag late fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        front_buf[i] <= '0;
        back_buf[i]  <= '0;
      end
      back_full     <= 1'b0;
      fetch_started <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      if (cap_vld) back_buf[idx_d] <= mem_rdata;
      if (state == IDLE && fetch_start) fetch_started <= 1'b1;
      if (swap_point) begin
        fetch_started <= 1'b0;
        if (back_full) begin
          for (int i = 0; i < WORDS_PER_LINE; i++) front_buf[i] <= back_buf[i];
          back_full <= 1'b0;
        end else if (fetch_started) begin
          underrun <= 1'b1;
        end
      end
      if (state == DRAIN) back_full <= 1'b1;
    end
  end

  // Select the word under the beam; hpos beyond the line store reads as blank.
  always_comb begin
    word_sel = hpos[9:5];
    cur_word = '0;
    if (word_sel < 5'(WORDS_PER_LINE)) cur_word = front_buf[word_sel];
  end

  // Registered pixel output, LSB of each word is the leftmost pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pixel <= 1'b0;
    else        pixel <= display_on ? cur_word[hpos[4:0]] : 1'b0;
  end

endmodule

// File: tb/tb_vga_line_fetch_arbiter.sv
// Directed bench for vga_line_fetch_arbiter with a small RAM model on the memory port.
module tb_vga_line_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        display_on;
  logic        host_valid;
  logic [13:0] host_addr;
  logic [31:0] host_data;
  logic        host_ready;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        pixel;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [1024];

  always #5 clk = ~clk;

  vga_line_fetch_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .host_valid (host_valid),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .host_ready (host_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pixel      (pixel),
    .underrun   (underrun)
  );

  // RAM model: read data follows the registered address, writes land on the clock edge.
  assign mem_rdata = ram[mem_addr[9:0]];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
    end else if (mem_we) begin
      ram[mem_addr[9:0]] <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hpos = 10'd0; vpos = 10'd0; display_on = 1'b0;
    host_valid = 1'b0; host_addr = '0; host_data = '0;
    tick(); tick();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 14'd0) begin errors++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
    checks++; if (pixel !== 1'b0) begin errors++; $display("FAIL reset_pixel got=%b exp=0", pixel); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_host_write();
    hpos = 10'd100; vpos = 10'd50;
    host_valid = 1'b1; host_addr = 14'h0005; host_data = 32'hA5A5A5A5;
    #1;
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL hw_ready got=%b exp=1", host_ready); end
    tick();
    host_valid = 1'b0;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL hw_we got=%b exp=1", mem_we); end
    checks++; if (mem_addr !== 14'd5) begin errors++; $display("FAIL hw_addr got=%0d exp=5", mem_addr); end
    checks++; if (mem_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL hw_wdata got=%h exp=a5a5a5a5", mem_wdata); end
    tick();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL hw_we_drop got=%b exp=0", mem_we); end
    checks++; if (ram[5] !== 32'hA5A5A5A5) begin errors++; $display("FAIL hw_ram got=%h exp=a5a5a5a5", ram[5]); end
  endtask

  task automatic test_back_to_back();
    host_valid = 1'b1; host_addr = 14'd20; host_data = 32'h00000001;
    #1;
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got=%b exp=1", host_ready); end
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 14'd20) begin errors++; $display("FAIL b2b_first got we=%b addr=%0d exp we=1 addr=20", mem_we, mem_addr); end
    host_addr = 14'd100; host_data = 32'hDEADBEEF;
    #1;
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got=%b exp=1", host_ready); end
    tick();
    host_valid = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 14'd100 || mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL b2b_second got we=%b addr=%0d data=%h exp we=1 addr=100 data=deadbeef", mem_we, mem_addr, mem_wdata);
    end
    tick();
  endtask

  task automatic test_fetch_priority();
    hpos = 10'd640; vpos = 10'd10;
    host_valid = 1'b1; host_addr = 14'h123; host_data = 32'h55;
    #1;
    checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL prio_start_ready got=%b exp=0", host_ready); end
    tick(); hpos = hpos + 10'd1;
    for (int k = 0; k < 20; k++) begin
      checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL prio_ready k=%0d got=%b exp=0", k, host_ready); end
      tick(); hpos = hpos + 10'd1;
      checks++; if (mem_addr !== 14'(220 + k) || mem_we !== 1'b0) begin
        errors++; $display("FAIL prio_addr k=%0d got addr=%0d we=%b exp addr=%0d we=0", k, mem_addr, mem_we, 220 + k);
      end
    end
    checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL prio_drain_ready got=%b exp=0", host_ready); end
    tick(); hpos = hpos + 10'd1;
    #1;
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL prio_after_ready got=%b exp=1", host_ready); end
    tick();
    host_valid = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 14'h123) begin
      errors++; $display("FAIL prio_write got we=%b addr=%h exp we=1 addr=123", mem_we, mem_addr);
    end
    hpos = 10'd799; tick();
    hpos = 10'd0; tick();
  endtask

  task automatic test_pixel();
    vpos = 10'd0; hpos = 10'd640;
    for (int k = 0; k < 24; k++) begin tick(); hpos = hpos + 10'd1; end
    hpos = 10'd799; tick();
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL pix_underrun got=%b exp=0", underrun); end
    vpos = 10'd1; hpos = 10'd0; display_on = 1'b1;
    tick();
    checks++; if (pixel !== 1'b1) begin errors++; $display("FAIL pix_h0 got=%b exp=1", pixel); end
    for (int h = 1; h < 32; h++) begin
      hpos = 10'(h);
      tick();
      checks++; if (pixel !== 1'b0) begin errors++; $display("FAIL pix_h%0d got=%b exp=0", h, pixel); end
    end
    hpos = 10'd0; display_on = 1'b0;
    tick();
    checks++; if (pixel !== 1'b0) begin errors++; $display("FAIL pix_blank got=%b exp=0", pixel); end
  endtask

  task automatic test_vmax();
    vpos = 10'd524; hpos = 10'd640;
    tick(); hpos = hpos + 10'd1;
    for (int k = 0; k < 20; k++) begin
      tick(); hpos = hpos + 10'd1;
      checks++; if (mem_addr !== 14'(k) || mem_we !== 1'b0) begin
        errors++; $display("FAIL vmax_addr k=%0d got addr=%0d we=%b exp addr=%0d we=0", k, mem_addr, mem_we, k);
      end
    end
    tick(); tick();
    hpos = 10'd799; tick();
    for (int i = 0; i < 3; i++) begin
      vpos = (i == 0) ? 10'd479 : (i == 1) ? 10'd500 : 10'd523;
      hpos = 10'd640; host_valid = 1'b1; host_addr = 14'(512 + i); host_data = 32'(i + 7);
      #1;
      checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL nofetch_ready v=%0d got=%b exp=1", vpos, host_ready); end
      tick();
      host_valid = 1'b0;
      checks++; if (mem_we !== 1'b1 || mem_addr !== 14'(512 + i)) begin
        errors++; $display("FAIL nofetch_write v=%0d got we=%b addr=%0d exp we=1 addr=%0d", vpos, mem_we, mem_addr, 512 + i);
      end
      hpos = 10'd700; tick();
    end
  endtask

  task automatic test_underrun();
    vpos = 10'd5; hpos = 10'd640;
    tick();
    hpos = 10'd799;
    tick();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got=%b exp=1", underrun); end
    hpos = 10'd100;
    for (int k = 0; k < 25; k++) tick();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got=%b exp=1", underrun); end
    hpos = 10'd799; tick();
    hpos = 10'd0; tick();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_after_swap got=%b exp=1", underrun); end
  endtask

  task automatic test_reset_mid_fetch();
    vpos = 10'd20; hpos = 10'd640;
    tick(); hpos = 10'd641;
    for (int k = 0; k < 7; k++) tick();
    hpos = 10'd100; host_valid = 1'b1; host_addr = 14'd7; host_data = 32'h77;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstf_we got=%b exp=0", mem_we); end
    checks++; if (pixel !== 1'b0) begin errors++; $display("FAIL rstf_pixel got=%b exp=0", pixel); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rstf_underrun got=%b exp=0", underrun); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL rstf_ready got=%b exp=1", host_ready); end
    tick();
    host_valid = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 14'd7) begin
      errors++; $display("FAIL rstf_write got we=%b addr=%0d exp we=1 addr=7", mem_we, mem_addr);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_host_write();
    test_back_to_back();
    test_fetch_priority();
    test_pixel();
    test_vmax();
    test_underrun();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
